// File: rtl/serial_frame_deframer.sv
// Serial-to-parallel frame deframer: arms on ena, starts when ena falls, then shifts WORDS
// words of DATA_W bits from s_in and emits each one with its index and a one-cycle strobe.
module serial_frame_deframer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WORDS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              s_in,
    input  logic              msb_first,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned BitW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BitW-1:0]   LastBit  = BitW'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StShift} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BitW-1:0]   bit_cnt_q;
    logic [ADDR_W-1:0] word_cnt_q;
    logic              mode_q, mode_d;

    // The start edge samples bit 0 before mode_q is loaded, so use the live pin there.
    always_comb begin
        mode_d  = (state_q == StArmed) ? msb_first : mode_q;
        shift_d = mode_d ? {shift_q[DATA_W-2:0], s_in} : {s_in, shift_q[DATA_W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            mode_q     <= 1'b0;
            addr_out   <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ena) state_q <= StArmed;
                end
                StArmed: begin
                    if (!ena) begin
                        state_q    <= StShift;
                        mode_q     <= msb_first;
                        shift_q    <= shift_d;
                        bit_cnt_q  <= BitW'(1);
                        word_cnt_q <= '0;
                    end
                end
                StShift: begin
                    shift_q <= shift_d;
                    if (bit_cnt_q == LastBit) begin
                        data_out  <= shift_d;
                        addr_out  <= word_cnt_q;
                        valid_out <= 1'b1;
                        bit_cnt_q <= '0;
                        if (word_cnt_q == LastWord) begin
                            frame_done <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            if (ena) state_q <= StArmed;
                        end
                    end else if (ena) begin
                        // Abort: partial word is dropped, next frame restarts at word 0.
                        state_q <= StArmed;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_deframer.sv
// Scoreboard bench for serial_frame_deframer: default 4-bit/16-word instance and an
// 8-bit/3-word instance, with abort, async reset and ena-on-completion cases.
module tb_serial_frame_deframer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ena_a = 1'b0, s_a = 1'b0, msb_a = 1'b0;
    logic [3:0] addr_a, data_a;
    logic       valid_a, done_a, busy_a;

    logic       ena_b = 1'b0, s_b = 1'b0, msb_b = 1'b0;
    logic [1:0] addr_b;
    logic [7:0] data_b;
    logic       valid_b, done_b, busy_b;

    serial_frame_deframer #(.DATA_W(4), .ADDR_W(4), .WORDS(16)) u_dut_a (
        .clk(clk), .rst(rst), .ena(ena_a), .s_in(s_a), .msb_first(msb_a),
        .addr_out(addr_a), .data_out(data_a), .valid_out(valid_a),
        .frame_done(done_a), .busy(busy_a)
    );

    serial_frame_deframer #(.DATA_W(8), .ADDR_W(2), .WORDS(3)) u_dut_b (
        .clk(clk), .rst(rst), .ena(ena_b), .s_in(s_b), .msb_first(msb_b),
        .addr_out(addr_b), .data_out(data_b), .valid_out(valid_b),
        .frame_done(done_b), .busy(busy_b)
    );

    typedef struct {
        int unsigned addr;
        int unsigned data;
        bit          done;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[n-1-i] = v[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", 32'(valid_a), 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check("a_addr", 32'(addr_a), e_a.addr);
                check("a_data", 32'(data_a), e_a.data);
                check("a_done", 32'(done_a), 32'(e_a.done));
            end
        end else if (done_a !== 1'b0 || valid_a !== 1'b0) begin
            check("a_stray_strobe", 32'({valid_a, done_a}), 32'd0);
        end
        if (valid_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", 32'(valid_b), 32'd0);
            end else begin
                e_b = q_b.pop_front();
                check("b_addr", 32'(addr_b), e_b.addr);
                check("b_data", 32'(data_b), e_b.data);
                check("b_done", 32'(done_b), 32'(e_b.done));
            end
        end else if (done_b !== 1'b0 || valid_b !== 1'b0) begin
            check("b_stray_strobe", 32'({valid_b, done_b}), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ena(input int u, input logic v);
        if (u == 0) ena_a = v;
        else        ena_b = v;
    endtask

    task automatic arm(input int u, input logic msb);
        if (u == 0) msb_a = msb;
        else        msb_b = msb;
        set_ena(u, 1'b1);
        tick();
        tick();
        set_ena(u, 1'b0);
    endtask

    // bits_t[0] goes on the wire first.
    task automatic send_word(input int u, input logic [7:0] bits_t, input int n, input bit msb,
                             input int unsigned addr, input bit done);
        exp_t e;
        e.addr = addr;
        e.data = 32'(msb ? rev(bits_t, n) : (bits_t & 8'((1 << n) - 1)));
        e.done = done;
        if (u == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (u == 0) s_a = bits_t[i];
            else        s_b = bits_t[i];
            tick();
        end
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // LSB-first full frame, values 1..15,0
        arm(0, 1'b0);
        for (int i = 0; i < 16; i++) send_word(0, 8'((i + 1) % 16), 4, 1'b0, i, i == 15);
        tick();
        check("t1_busy_after", 32'(busy_a), 32'd0);
        check("t1_sb_empty", 32'(q_a.size()), 32'd0);

        // MSB-first, same wire bits; pin change mid-frame must be ignored
        arm(0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_word(0, 8'((i + 1) % 16), 4, 1'b1, i, i == 15);
            msb_a = 1'b0;
        end
        tick();
        check("t2_sb_empty", 32'(q_a.size()), 32'd0);

        // abort after 2 words + 2 bits
        arm(0, 1'b0);
        send_word(0, 8'h5, 4, 1'b0, 0, 1'b0);
        send_word(0, 8'h6, 4, 1'b0, 1, 1'b0);
        s_a = 1'b1; tick();
        s_a = 1'b1; tick();
        ena_a = 1'b1; tick();
        check("t3_busy_armed", 32'(busy_a), 32'd1);
        ena_a = 1'b0;
        send_word(0, 8'hC, 4, 1'b0, 0, 1'b0);
        s_a = 1'b1; tick();
        s_a = 1'b0; tick();
        check("t3_sb_empty", 32'(q_a.size()), 32'd0);

        // async reset mid-shift, between edges
        #2;
        rst = 1'b1;
        #1;
        check("t4_addr", 32'(addr_a), 32'd0);
        check("t4_data", 32'(data_a), 32'd0);
        check("t4_valid", 32'(valid_a), 32'd0);
        check("t4_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_a = 1'(i);
            tick();
        end
        check("t4_busy_idle", 32'(busy_a), 32'd0);

        // ena high on the completing edge of word 5
        arm(0, 1'b0);
        for (int i = 0; i < 5; i++) send_word(0, 8'(3 * i + 2), 4, 1'b0, i, 1'b0);
        begin
            exp_t e;
            e.addr = 5; e.data = 32'h9; e.done = 1'b0;
            q_a.push_back(e);
        end
        s_a = 1'b1; tick();
        s_a = 1'b0; tick();
        s_a = 1'b0; tick();
        s_a = 1'b1; ena_a = 1'b1; tick();
        check("t6_busy_armed", 32'(busy_a), 32'd1);
        ena_a = 1'b0;
        for (int i = 0; i < 16; i++) send_word(0, 8'(15 - i), 4, 1'b0, i, i == 15);
        tick();
        check("t6_busy_after", 32'(busy_a), 32'd0);
        check("t6_sb_empty", 32'(q_a.size()), 32'd0);

        // 8-bit / 3-word instance
        arm(1, 1'b0);
        send_word(1, 8'hA5, 8, 1'b0, 0, 1'b0);
        send_word(1, 8'h3C, 8, 1'b0, 1, 1'b0);
        send_word(1, 8'hFF, 8, 1'b0, 2, 1'b1);
        tick();
        check("t5_busy_after", 32'(busy_b), 32'd0);
        check("t5_sb_empty", 32'(q_b.size()), 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
